aether_engine_bram_mem: RTL and testbench
=========================================

// Module: aether_engine_bram_mem
// PURPOSE
//  Parametrised on-chip memory engine for the aether engine: executes one WRITE or READ task over an address
//  range [start, end] with programmable stride, backed by single_port_bram. Successor to the fixed 16-bit,
//  64K-deep engine: adds width/depth parameters, stride, valid/ready handshakes on both streams,
//  read backpressure via 2-entry output buffer, abort, and illegal-task error reporting.
// PARAMETERS
//  DataWidth   16        bits per word
//  AddrWidth   16        address bits; all address ports use this width
//  Depth       2**16     words in memory; must satisfy Depth <= 2**AddrWidth
// PORTS
//  clk_i              in   1          single clock, all logic rising-edge
//  rst_i              in   1          reset, asynchronous, active-high
//  command_i          in   2          0 IDLE, 1 WRITE, 2 READ, 3 reserved (illegal)
//  start_address_i    in   AddrWidth  first address, sampled at task accept
//  end_address_i      in   AddrWidth  last allowed address (inclusive), sampled at task accept
//  stride_i           in   AddrWidth  address increment, sampled at task accept; 0 is illegal
//  abort_i            in   1          cancel current task
//  data_write_i       in   DataWidth  write data
//  data_write_valid_i in   1          write beat offered
//  data_write_ready_o out  1          engine accepts write beat
//  data_read_o        out  DataWidth  read data (0 when data_read_valid_o low)
//  data_read_valid_o  out  1          read beat offered
//  data_read_ready_i  in   1          consumer accepts read beat
//  busy_o             out  1          task in progress
//  task_finished_o    out  1          one-cycle pulse, task completed normally
//  error_o            out  1          one-cycle pulse, task request rejected
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; read buffer emptied; memory contents not cleared.
//  - FSM: IDLE -> WRITE | READ on legal accept; WRITE/READ -> DONE after last beat; DONE -> IDLE (1 cycle,
//    task_finished_o=1); any busy state -> IDLE on abort_i (no finished pulse).
//  - Accept: only in IDLE, command_i!=0, abort_i low. abort_i beats command_i in same cycle.
//    Rejected (error_o pulse next cycle, stay IDLE): cmd 3, stride 0, start>end, end>=Depth.
//  - command_i while busy_o=1 is ignored, not queued.
//  - Beat count N = (end-start)/stride + 1 (integer). Beat k uses address start + k*stride.
//    Next-address math is AddrWidth+1 bits; last beat when addr+stride > end (covers wrap at 2**AddrWidth).
//  - busy_o = 1 in WRITE, READ, DONE; registered, high the cycle after accept.
//  - WRITE: data_write_ready_o=1 for the whole WRITE state. Beat = valid&&ready -> mem[addr] written
//    same edge. After beat N the FSM enters DONE; task_finished_o pulses the cycle after beat N.
//  - READ: BRAM read latency is 1. A read is issued when (in-flight + buffered) < 2. Buffer is a 2-entry FIFO.
//    data_read_valid_o = buffer not empty. Beat = valid&&ready pops the FIFO. No data lost or duplicated
//    under any ready pattern. First valid no earlier than 2 cycles after accept.
//    FSM enters DONE after beat N is popped; task_finished_o pulses the next cycle.
//    data_read_o is held stable while valid&&!ready.
//  - abort_i in WRITE/READ: next cycle busy_o=0, ready/valid=0, FIFO flushed, in-flight read discarded.
//    Writes already committed stay committed. abort_i in IDLE/DONE has no effect; DONE completes normally.
//  - Reset mid-task behaves like abort with outputs forced 0 immediately (asynchronous).
// STRUCTURE
//  - aether_mem_pkg: mem_cmd_e {MEM_IDLE, MEM_WRITE, MEM_READ, MEM_RSVD}; mem_state_e {S_IDLE, S_WRITE,
//    S_READ, S_DONE}.
//  - Sub-module: existing single_port_bram (DataWidth, Depth). FSM, address generator, beat counter and
//    2-entry read FIFO are inline; in-flight flag is 1 bit.
//  - Immediate assertions under an assertion-enable: legal state encoding, FIFO never over/underflows,
//    address never >= Depth when a read or write is issued.
// TESTING
//  1. WRITE start=0 end=3 stride=1, valid toggling 1,0,1,1,0,1 with data A0..A3 -> mem[0..3]=A0..A3;
//     finished 1 cycle after 4th beat.
//  2. READ 0..3, ready low 5 cycles then high -> A0,A1,A2,A3 once each in order; at most 2 reads
//     outstanding; finished after 4th pop.
//  3. WRITE start=1 end=6 stride=2 -> exactly 3 beats at addr 1,3,5; addr 6 untouched.
//  4. cmd=3; start=5 end=2; stride=0; end=Depth -> error_o 1-cycle pulse each, busy_o stays 0.
//  5. READ 0..9, abort after beat 2 -> valid 0 next cycle, busy_o 0, no finished;
//     new READ 0..0 then returns mem[0].
//  6. rst_i mid-WRITE after 2 beats -> outputs 0 immediately; after release READ 0..1 returns written data.
//  7. Edge: AddrWidth=4 Depth=16, start=14 end=15 stride=3 -> 1 beat at addr 14, no wrap to addr 1.

Source files
------------

// File: rtl/aether_mem_pkg.sv
// Shared types for the aether engine on-chip memory block: command encoding
// presented on command_i and the engine's control states.
package aether_mem_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_WRITE = 2'd1,
    MEM_READ  = 2'd2,
    MEM_RSVD  = 2'd3
  } mem_cmd_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } mem_state_e;

  // Entries in the read-side output buffer; also the cap on reads in flight
  // plus reads buffered.
  localparam int unsigned ReadBufDepth = 2;

endpackage

// File: rtl/single_port_bram.sv
// Single-port block RAM, one access per cycle, registered read data
// (read latency 1). Contents are never initialised or cleared.
module single_port_bram #(
  parameter int DataWidth = 16,
  parameter int Depth     = 2**16,
  parameter int AddrWidth = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                 clk_i,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] r_mem [Depth];

  // Write on we_i, otherwise read into the output register.
  // NOTE: storage arrays get no reset branch; a reset would force the tools to
  // build the memory from flops instead of a RAM macro.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        r_mem[addr_i] <= wdata_i;
      end else begin
        rdata_o <= r_mem[addr_i];
      end
    end
  end

endmodule

// File: rtl/aether_engine_bram_mem.sv
// Aether engine memory task engine: runs one WRITE or READ task over
// [start, end] with a programmable stride against a single-port BRAM.
// Writes stream in on a valid/ready port; reads stream out through a
// 2-entry buffer so the consumer may apply backpressure freely.
module aether_engine_bram_mem
  import aether_mem_pkg::*;
#(
  parameter int DataWidth     = 16,
  parameter int AddrWidth     = 16,
  parameter int Depth         = 2**16,
  parameter bit EnableAsserts = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           command_i,
  input  logic [AddrWidth-1:0] start_address_i,
  input  logic [AddrWidth-1:0] end_address_i,
  input  logic [AddrWidth-1:0] stride_i,
  input  logic                 abort_i,
  input  logic [DataWidth-1:0] data_write_i,
  input  logic                 data_write_valid_i,
  output logic                 data_write_ready_o,
  output logic [DataWidth-1:0] data_read_o,
  output logic                 data_read_valid_o,
  input  logic                 data_read_ready_i,
  output logic                 busy_o,
  output logic                 task_finished_o,
  output logic                 error_o
);

  localparam int BramAw = (Depth > 1) ? $clog2(Depth) : 1;
  // Depth expressed at the widened address width used for range checks.
  localparam logic [AddrWidth:0] DepthW = (AddrWidth+1)'(Depth);

  mem_state_e           r_state;
  logic [AddrWidth-1:0] r_addr;
  logic [AddrWidth-1:0] r_end;
  logic [AddrWidth-1:0] r_stride;
  logic                 r_issue_done;
  logic                 r_inflight;
  logic                 r_error;
  logic [DataWidth-1:0] r_fifo [ReadBufDepth];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_count;

  mem_cmd_e             w_cmd;
  logic                 w_req;
  logic                 w_illegal;
  logic                 w_accept;
  logic                 w_reject;
  logic                 w_abort;
  logic [AddrWidth:0]   w_next_addr;
  logic                 w_last;
  logic                 w_wr_beat;
  logic                 w_rd_issue;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_last_pop;
  logic                 w_bram_en;
  logic [DataWidth-1:0] w_bram_rdata;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign w_cmd     = mem_cmd_e'(command_i);
  assign w_req     = (r_state == S_IDLE) && (w_cmd != MEM_IDLE) && !abort_i;
  assign w_illegal = (w_cmd == MEM_RSVD)
                  || (stride_i == '0)
                  || (start_address_i > end_address_i)
                  || ({1'b0, end_address_i} >= DepthW);
  assign w_accept  = w_req && !w_illegal;
  assign w_reject  = w_req &&  w_illegal;
  assign w_abort   = abort_i && ((r_state == S_WRITE) || (r_state == S_READ));

  // One extra bit so an addr+stride that passes 2**AddrWidth still reads as
  // "beyond end" instead of wrapping back into the range.
  assign w_next_addr = {1'b0, r_addr} + {1'b0, r_stride};
  assign w_last      = w_next_addr > {1'b0, r_end};

  // ---------------------------------------------------------------------------
  // Beat and buffer handshakes
  // ---------------------------------------------------------------------------
  assign w_wr_beat  = (r_state == S_WRITE) && data_write_valid_i;
  assign w_rd_issue = (r_state == S_READ) && !r_issue_done
                   && ((r_count + {1'b0, r_inflight}) < 2'(ReadBufDepth));
  assign w_push     = r_inflight;
  assign w_pop      = (r_count != 2'd0) && data_read_ready_i;
  // The final pop: everything issued, nothing in flight, one word left.
  assign w_last_pop = (r_state == S_READ) && r_issue_done && !r_inflight
                   && (r_count == 2'd1) && w_pop;

  assign w_bram_en  = w_wr_beat || w_rd_issue;

  // ---------------------------------------------------------------------------
  // Outputs (all decoded from registered state so reset clears them at once)
  // ---------------------------------------------------------------------------
  assign busy_o             = (r_state != S_IDLE);
  assign data_write_ready_o = (r_state == S_WRITE);
  assign task_finished_o    = (r_state == S_DONE);
  assign error_o            = r_error;
  assign data_read_valid_o  = (r_count != 2'd0);
  assign data_read_o        = data_read_valid_o ? r_fifo[r_rd_ptr] : '0;

  // Task control FSM.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from the pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= (w_cmd == MEM_WRITE) ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else if (w_wr_beat && w_last) begin
            r_state <= S_DONE;
          end
        end
        S_READ: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else if (w_last_pop) begin
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Address generator: latch the task window on accept, step on every access.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr       <= '0;
      r_end        <= '0;
      r_stride     <= '0;
      r_issue_done <= 1'b0;
    end else if (w_accept) begin
      r_addr       <= start_address_i;
      r_end        <= end_address_i;
      r_stride     <= stride_i;
      r_issue_done <= 1'b0;
    end else if (w_bram_en) begin
      if (w_last) begin
        r_issue_done <= 1'b1;
      end else begin
        r_addr <= w_next_addr[AddrWidth-1:0];
      end
    end
  end

  // Reject pulse, one cycle after the offending request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_error <= 1'b0;
    end else begin
      r_error <= w_reject;
    end
  end

  // Read buffer bookkeeping: in-flight flag, pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_inflight <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else if (w_abort) begin
      // Drop buffered words and the read still coming back from the BRAM.
      r_inflight <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_inflight <= w_rd_issue;
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Read buffer storage; qualified by r_count, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (w_push && !w_abort) begin
      r_fifo[r_wr_ptr] <= w_bram_rdata;
    end
  end

  single_port_bram #(
    .DataWidth (DataWidth),
    .Depth     (Depth),
    .AddrWidth (BramAw)
  ) u_bram (
    .clk_i   (clk_i),
    .en_i    (w_bram_en),
    .we_i    (w_wr_beat),
    .addr_i  (r_addr[BramAw-1:0]),
    .wdata_i (data_write_i),
    .rdata_o (w_bram_rdata)
  );

  // Runtime sanity checks: state encoding, buffer occupancy, access range.
  always_ff @(posedge clk_i) begin
    if (EnableAsserts && !rst_i) begin
      assert (r_state inside {S_IDLE, S_WRITE, S_READ, S_DONE});
      assert (r_count <= 2'(ReadBufDepth));
      assert (!(w_push && !w_pop && (r_count == 2'(ReadBufDepth))));
      assert (!(w_bram_en && ({1'b0, r_addr} >= DepthW)));
    end
  end

endmodule

// File: tb/tb_aether_engine_bram_mem.sv
// Self-checking bench for aether_engine_bram_mem. A plain array models the
// memory contents; expected beat counts and addresses come from the task
// window arithmetic. Inputs are driven and outputs sampled on the falling edge.
module tb_aether_engine_bram_mem;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    cmd;
  logic [AW-1:0] sa, ea, st;
  logic          abort;
  logic [DW-1:0] wd;
  logic          wv, wr;
  logic [DW-1:0] rd;
  logic          rv, rr;
  logic          busy, fin, err;

  // Small instance for the address-wrap corner.
  logic [1:0]    s_cmd;
  logic [3:0]    s_sa, s_ea, s_st;
  logic          s_abort;
  logic [DW-1:0] s_wd;
  logic          s_wv, s_wr;
  logic [DW-1:0] s_rd;
  logic          s_rv, s_rr;
  logic          s_busy, s_fin, s_err;

  logic [DW-1:0] ref_mem [DEPTH];
  bit            pat_bits [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  aether_engine_bram_mem #(
    .DataWidth (DW),
    .AddrWidth (AW),
    .Depth     (DEPTH)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .command_i          (cmd),
    .start_address_i    (sa),
    .end_address_i      (ea),
    .stride_i           (st),
    .abort_i            (abort),
    .data_write_i       (wd),
    .data_write_valid_i (wv),
    .data_write_ready_o (wr),
    .data_read_o        (rd),
    .data_read_valid_o  (rv),
    .data_read_ready_i  (rr),
    .busy_o             (busy),
    .task_finished_o    (fin),
    .error_o            (err)
  );

  aether_engine_bram_mem #(
    .DataWidth (DW),
    .AddrWidth (4),
    .Depth     (16)
  ) dut_small (
    .clk_i              (clk),
    .rst_i              (rst),
    .command_i          (s_cmd),
    .start_address_i    (s_sa),
    .end_address_i      (s_ea),
    .stride_i           (s_st),
    .abort_i            (s_abort),
    .data_write_i       (s_wd),
    .data_write_valid_i (s_wv),
    .data_write_ready_o (s_wr),
    .data_read_o        (s_rd),
    .data_read_valid_o  (s_rv),
    .data_read_ready_i  (s_rr),
    .busy_o             (s_busy),
    .task_finished_o    (s_fin),
    .error_o            (s_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present a command for one cycle; returns at the falling edge after accept.
  task automatic issue(input logic [1:0] c, input int s, input int e, input int str);
    cmd = c; sa = AW'(s); ea = AW'(e); st = AW'(str);
    @(negedge clk);
    cmd = 2'd0;
  endtask

  // WRITE task; pat selects the fixed 1,0,1,1,0,1 valid pattern with data
  // 0xA0+k, otherwise random valid and data. rst_after>0 asserts reset once
  // that many beats have been taken.
  task automatic run_write(input int s, input int e, input int str,
                           input bit pat, input int rst_after);
    int n, idx, cyc;
    n = (e - s) / str + 1;
    issue(2'd1, s, e, str);
    check("wr_busy", 32'(busy), 1);
    check("wr_ready", 32'(wr), 1);
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 500) begin
      if (rst_after > 0 && idx == rst_after) break;
      wv = pat ? pat_bits[cyc % 6] : 1'($urandom_range(0, 1));
      wd = pat ? DW'(16'h00A0 + idx) : DW'($urandom);
      if (wv && wr) begin
        ref_mem[s + idx * str] = wd;
        idx++;
      end
      cyc++;
      @(negedge clk);
    end
    wv = 1'b0;
    if (rst_after > 0) begin
      rst = 1'b1;
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_ready", 32'(wr), 0);
      check("rst_fin", 32'(fin), 0);
      check("rst_valid", 32'(rv), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
    end else begin
      check("wr_beats", 32'(idx), 32'(n));
      check("wr_fin", 32'(fin), 1);
      check("wr_ready_done", 32'(wr), 0);
      @(negedge clk);
      check("wr_fin_clear", 32'(fin), 0);
      check("wr_idle", 32'(busy), 0);
    end
  endtask

  // READ task; mode 1 holds ready low for 5 cycles then high, mode 0 is
  // random ready. abort_after>0 aborts once that many beats have been popped.
  task automatic run_read(input int s, input int e, input int str,
                          input int mode, input int abort_after);
    int n, idx, cyc;
    bit stall;
    logic [DW-1:0] prev_d;
    n = (e - s) / str + 1;
    issue(2'd2, s, e, str);
    idx = 0;
    cyc = 0;
    stall = 1'b0;
    prev_d = '0;
    while (idx < n && cyc < 1000) begin
      if (cyc < 2) check("rd_not_early", 32'(rv), 0);
      if (stall) begin
        check("rd_hold_valid", 32'(rv), 1);
        check("rd_hold_data", 32'(rd), 32'(prev_d));
      end
      if (!rv) check("rd_zero_idle", 32'(rd), 0);
      rr = (mode == 1) ? (cyc >= 5) : 1'($urandom_range(0, 1));
      stall = rv && !rr;
      prev_d = rd;
      if (rv && rr) begin
        check("rd_data", 32'(rd), 32'(ref_mem[s + idx * str]));
        idx++;
      end
      cyc++;
      @(negedge clk);
      if (abort_after > 0 && idx == abort_after) break;
    end
    rr = 1'b0;
    if (abort_after > 0) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("ab_busy", 32'(busy), 0);
      check("ab_valid", 32'(rv), 0);
      check("ab_fin", 32'(fin), 0);
      @(negedge clk);
      check("ab_fin_later", 32'(fin), 0);
      check("ab_valid_later", 32'(rv), 0);
    end else begin
      check("rd_beats", 32'(idx), 32'(n));
      check("rd_fin", 32'(fin), 1);
      check("rd_valid_done", 32'(rv), 0);
      @(negedge clk);
      check("rd_fin_clear", 32'(fin), 0);
      check("rd_idle", 32'(busy), 0);
    end
  endtask

  // A request that must be rejected: error pulse next cycle, never busy.
  task automatic reject(input string tag, input logic [1:0] c, input int s,
                        input int e, input int str);
    issue(c, s, e, str);
    check({tag, "_err"}, 32'(err), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    @(negedge clk);
    check({tag, "_err_clear"}, 32'(err), 0);
    check({tag, "_busy_after"}, 32'(busy), 0);
  endtask

  task automatic s_issue(input logic [1:0] c, input int s, input int e, input int str);
    s_cmd = c; s_sa = 4'(s); s_ea = 4'(e); s_st = 4'(str);
    @(negedge clk);
    s_cmd = 2'd0;
  endtask

  // One-beat write on the small instance; finished must follow immediately.
  task automatic s_write_one(input string tag, input int s, input int e,
                             input int str, input logic [DW-1:0] d);
    s_issue(2'd1, s, e, str);
    check({tag, "_ready"}, 32'(s_wr), 1);
    s_wv = 1'b1;
    s_wd = d;
    @(negedge clk);
    s_wv = 1'b0;
    check({tag, "_fin"}, 32'(s_fin), 1);
    @(negedge clk);
    check({tag, "_idle"}, 32'(s_busy), 0);
  endtask

  // One-beat read on the small instance with ready held high.
  task automatic s_read_one(input string tag, input int s, input int e,
                            input int str, input logic [DW-1:0] exp);
    int k;
    s_issue(2'd2, s, e, str);
    s_rr = 1'b1;
    k = 0;
    while (!s_rv && k < 10) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, 32'(s_rv), 1);
    check({tag, "_data"}, 32'(s_rd), 32'(exp));
    @(negedge clk);
    check({tag, "_fin"}, 32'(s_fin), 1);
    s_rr = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, 32'(s_busy), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, e, str;
    rst = 1'b1; cmd = '0; sa = '0; ea = '0; st = '0; abort = 1'b0;
    wd = '0; wv = 1'b0; rr = 1'b0;
    s_cmd = '0; s_sa = '0; s_ea = '0; s_st = '0; s_abort = 1'b0;
    s_wd = '0; s_wv = 1'b0; s_rr = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_ready", 32'(wr), 0);
    check("reset_valid", 32'(rv), 0);
    check("reset_data", 32'(rd), 0);
    check("reset_fin", 32'(fin), 0);
    check("reset_err", 32'(err), 0);
    rst = 1'b0;
    @(negedge clk);

    // Known background contents for everything the later reads touch.
    run_write(0, 63, 1, 1'b0, 0);
    // Fixed valid pattern, four beats A0..A3.
    run_write(0, 3, 1, 1'b1, 0);
    // Read back with ready held off for five cycles.
    run_read(0, 3, 1, 1, 0);
    // Strided write: beats at 1,3,5 only; 6 must keep its old value.
    run_write(1, 6, 2, 1'b0, 0);
    run_read(0, 9, 1, 0, 0);

    // Illegal requests.
    reject("rsvd", 2'd3, 0, 3, 1);
    reject("start_gt_end", 2'd1, 5, 2, 1);
    reject("stride0", 2'd2, 0, 3, 0);
    reject("end_depth", 2'd1, 0, DEPTH, 1);

    // Abort in the same cycle as a command wins: nothing starts.
    abort = 1'b1;
    issue(2'd1, 0, 3, 1);
    abort = 1'b0;
    check("abort_cmd_busy", 32'(busy), 0);
    check("abort_cmd_err", 32'(err), 0);

    // Abort mid-read, then a fresh single-beat read.
    run_read(0, 9, 1, 0, 2);
    run_read(0, 0, 1, 0, 0);

    // Random tasks inside the pre-written window.
    for (int t = 0; t < 8; t++) begin
      s   = $urandom_range(0, 40);
      e   = s + $urandom_range(0, 20);
      str = $urandom_range(1, 7);
      run_write(s, e, str, 1'b0, 0);
      run_read(s, e, str, 0, 0);
    end

    // Reset after two write beats; those two stay committed.
    run_write(0, 3, 1, 1'b0, 2);
    run_read(0, 1, 1, 0, 0);

    // Narrow-address corner: 14 + 3 overflows 4 bits, must not wrap to 1.
    s_write_one("s_w1", 1, 1, 1, 16'h1111);
    s_write_one("s_w14", 14, 15, 3, 16'h2222);
    s_read_one("s_r1", 1, 1, 1, 16'h1111);
    s_read_one("s_r14", 14, 15, 3, 16'h2222);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
